// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and forward-select encoding.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RAW  = 5;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;
   localparam logic [3:0] ALU_SRA = 4'd8;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_EXM = 2'd1,
      FWD_MWB = 2'd2
   } fwd_sel_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forward-source select for one EX operand; EX/MEM wins over MEM/WB, x0 never forwards.
module fwd_unit
   import cpu_pkg::*;
#(
   parameter int unsigned RAW = cpu_pkg::RAW
) (
   input  logic [RAW-1:0] rs,
   input  logic           exm_regwrite,
   input  logic [RAW-1:0] exm_rd,
   input  logic           mwb_regwrite,
   input  logic [RAW-1:0] mwb_rd,
   output fwd_sel_t       sel
);

   always_comb begin
      sel = FWD_REG;
      if (exm_regwrite && (exm_rd != '0) && (exm_rd == rs)) begin
         sel = FWD_EXM;
      end else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == rs)) begin
         sel = FWD_MWB;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand select and load-use bubble insertion.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = cpu_pkg::XLEN,
   parameter int unsigned RAW  = cpu_pkg::RAW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RAW-1:0]  id_rs1_addr,
   input  logic [RAW-1:0]  id_rs2_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic            id_use_rs2,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alusrc,
   input  logic [3:0]      id_aluctrl,
   input  logic [RAW-1:0]  id_rd_addr,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_memwrite,
   input  logic            id_memtoreg,
   input  logic            freeze,
   input  logic            flush,
   input  logic            exm_regwrite,
   input  logic [RAW-1:0]  exm_rd,
   input  logic [XLEN-1:0] exm_data,
   input  logic            mwb_regwrite,
   input  logic [RAW-1:0]  mwb_rd,
   input  logic [XLEN-1:0] mwb_data,
   output logic            hazard_stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_src1,
   output logic [XLEN-1:0] ex_src2,
   output logic [3:0]      ex_aluctrl,
   output logic [XLEN-1:0] ex_store_data,
   output logic [RAW-1:0]  ex_rd,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            ex_memwrite,
   output logic            ex_memtoreg
);

   logic [RAW-1:0]  rs1_addr_q;
   logic [RAW-1:0]  rs2_addr_q;
   logic [XLEN-1:0] rs1_data_q;
   logic [XLEN-1:0] rs2_data_q;
   logic [XLEN-1:0] imm_q;
   logic            alusrc_q;

   fwd_sel_t        sel1;
   fwd_sel_t        sel2;
   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;
   logic [XLEN-1:0] opb;
   logic            rs_match;

   // Only a valid load still sitting in EX can starve the instruction in ID.
   always_comb begin
      rs_match = (ex_rd == id_rs1_addr) || (id_use_rs2 && (ex_rd == id_rs2_addr));
      hazard_stall = id_valid && ex_valid && ex_memread && (ex_rd != '0) && rs_match && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         alusrc_q    <= 1'b0;
         ex_aluctrl  <= '0;
         ex_rd       <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_memtoreg <= 1'b0;
      end else if (!freeze) begin
         if (flush || hazard_stall) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
         end else begin
            ex_valid    <= id_valid;
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            alusrc_q    <= id_alusrc;
            ex_aluctrl  <= id_aluctrl;
            ex_rd       <= id_rd_addr;
            ex_regwrite <= id_regwrite & id_valid;
            ex_memread  <= id_memread  & id_valid;
            ex_memwrite <= id_memwrite & id_valid;
            ex_memtoreg <= id_memtoreg & id_valid;
         end
      end
   end

   fwd_unit #(.RAW(RAW)) u_fwd_rs1 (
      .rs           (rs1_addr_q),
      .exm_regwrite (exm_regwrite),
      .exm_rd       (exm_rd),
      .mwb_regwrite (mwb_regwrite),
      .mwb_rd       (mwb_rd),
      .sel          (sel1)
   );

   fwd_unit #(.RAW(RAW)) u_fwd_rs2 (
      .rs           (rs2_addr_q),
      .exm_regwrite (exm_regwrite),
      .exm_rd       (exm_rd),
      .mwb_regwrite (mwb_regwrite),
      .mwb_rd       (mwb_rd),
      .sel          (sel2)
   );

   always_comb begin
      unique case (sel1)
         FWD_EXM: fwd1 = exm_data;
         FWD_MWB: fwd1 = mwb_data;
         default: fwd1 = rs1_data_q;
      endcase
      unique case (sel2)
         FWD_EXM: fwd2 = exm_data;
         FWD_MWB: fwd2 = mwb_data;
         default: fwd2 = rs2_data_q;
      endcase
   end

   // Shift amounts are clipped to 5 bits here so the ALU sees a clean operand.
   always_comb begin
      opb           = alusrc_q ? imm_q : fwd2;
      ex_src1       = fwd1;
      ex_store_data = fwd2;
      ex_src2       = opb;
      if (is_shift(ex_aluctrl)) begin
         ex_src2      = '0;
         ex_src2[4:0] = opb[4:0];
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus randomized traffic checked against a slot-level model of the ID/EX stage.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid, id_use_rs2, id_alusrc;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [3:0]  id_aluctrl;
   logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        freeze, flush;
   logic        exm_regwrite, mwb_regwrite;
   logic [4:0]  exm_rd, mwb_rd;
   logic [31:0] exm_data, mwb_data;
   logic        hazard_stall, ex_valid;
   logic [31:0] ex_src1, ex_src2, ex_store_data;
   logic [3:0]  ex_aluctrl;
   logic [4:0]  ex_rd;
   logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      logic        v;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic        alusrc;
      logic [3:0]  op;
      logic [3:0]  ctl;   // {regwrite, memread, memwrite, memtoreg}
   } slot_t;

   slot_t m;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RAW(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_use_rs2(id_use_rs2), .id_imm(id_imm), .id_alusrc(id_alusrc),
      .id_aluctrl(id_aluctrl), .id_rd_addr(id_rd_addr),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
      .freeze(freeze), .flush(flush),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .hazard_stall(hazard_stall), .ex_valid(ex_valid),
      .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_aluctrl(ex_aluctrl),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
      if (exm_regwrite && exm_rd != 0 && exm_rd == a) return exm_data;
      if (mwb_regwrite && mwb_rd != 0 && mwb_rd == a) return mwb_data;
      return d;
   endfunction

   task automatic clear_inputs();
      rst = 0; freeze = 0; flush = 0;
      id_valid = 0; id_use_rs2 = 0; id_alusrc = 0;
      id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_aluctrl = 0;
      id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
      exm_regwrite = 0; exm_rd = 0; exm_data = 0;
      mwb_regwrite = 0; mwb_rd = 0; mwb_data = 0;
   endtask

   // Compare all outputs against the model at negedge, then advance the model one clock.
   task automatic step();
      slot_t       n;
      logic        hz;
      logic [31:0] e2;
      @(negedge clk);
      hz = id_valid && m.v && m.ctl[2] && m.rd != 0 &&
           (m.rd == id_rs1_addr || (id_use_rs2 && m.rd == id_rs2_addr)) && !flush;
      check("hazard_stall", {31'd0, hazard_stall}, {31'd0, hz});
      check("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
      check("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      check("ex_ctl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, {28'd0, m.ctl});
      if (m.v) begin
         e2 = m.alusrc ? m.imm : fwd(m.rs2, m.d2);
         if (m.op == 6 || m.op == 7 || m.op == 8) e2 = e2 % 32;
         check("ex_src1", ex_src1, fwd(m.rs1, m.d1));
         check("ex_src2", ex_src2, e2);
         check("ex_store_data", ex_store_data, fwd(m.rs2, m.d2));
         check("ex_aluctrl", {28'd0, ex_aluctrl}, {28'd0, m.op});
      end
      n = m;
      if (rst) begin
         n = '{default: 0};
      end else if (freeze) begin
         n = m;
      end else if (flush || hz) begin
         n.v = 0; n.rd = 0; n.ctl = 0;
      end else begin
         n = '{v: id_valid, rs1: id_rs1_addr, rs2: id_rs2_addr, rd: id_rd_addr,
               d1: id_rs1_data, d2: id_rs2_data, imm: id_imm, alusrc: id_alusrc,
               op: id_aluctrl,
               ctl: {id_regwrite, id_memread, id_memwrite, id_memtoreg} & {4{id_valid}}};
      end
      @(posedge clk);
      #1;
      m = n;
   endtask

   initial begin
      m = '{default: 0};
      clear_inputs();
      rst = 1;
      step();
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_src1", ex_src1, 32'd0);
      check("rst_rd", {27'd0, ex_rd}, 32'd0);
      rst = 0;

      // ADD x3, x1, x2 with x1=5, x2=7
      id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rs1_data = 5; id_rs2_data = 7;
      id_use_rs2 = 1; id_aluctrl = 2; id_rd_addr = 3; id_regwrite = 1;
      step();
      check("load_valid", {31'd0, ex_valid}, 32'd1);
      check("load_src1", ex_src1, 32'd5);
      check("load_src2", ex_src2, 32'd7);
      check("load_aluctrl", {28'd0, ex_aluctrl}, 32'd2);

      // Forward priority on rs1 = x3
      id_rs1_addr = 3; id_rs1_data = 32'h99;
      step();
      clear_inputs();
      exm_regwrite = 1; exm_rd = 3; exm_data = 32'h10;
      mwb_regwrite = 1; mwb_rd = 3; mwb_data = 32'h20;
      #1 check("fwd_exm", ex_src1, 32'h10);
      exm_regwrite = 0;
      #1 check("fwd_mwb", ex_src1, 32'h20);
      exm_regwrite = 1; exm_rd = 0; mwb_rd = 0;
      #1 check("fwd_x0", ex_src1, 32'h99);
      clear_inputs();

      // Load-use: LW x4 in EX, ADD x5, x4, x1 in ID
      id_valid = 1; id_rd_addr = 4; id_regwrite = 1; id_memread = 1; id_memtoreg = 1; id_aluctrl = 2;
      step();
      id_rs1_addr = 4; id_rs2_addr = 1; id_use_rs2 = 1; id_rd_addr = 5;
      id_memread = 0; id_memtoreg = 0;
      #1 check("lu_stall", {31'd0, hazard_stall}, 32'd1);
      step();
      check("lu_bubble", {31'd0, ex_valid}, 32'd0);
      check("lu_stall_drop", {31'd0, hazard_stall}, 32'd0);
      step();
      check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
      check("lu_add_rd", {27'd0, ex_rd}, 32'd5);
      check("lu_no_stall", {31'd0, hazard_stall}, 32'd0);

      // Flush, then freeze overriding flush
      flush = 1;
      step();
      check("flush_valid", {31'd0, ex_valid}, 32'd0);
      flush = 0; id_rd_addr = 7; id_rs1_addr = 1;
      step();
      freeze = 1; flush = 1; id_rd_addr = 9;
      for (int i = 0; i < 3; i++) begin
         step();
         check("frz_valid", {31'd0, ex_valid}, 32'd1);
         check("frz_rd", {27'd0, ex_rd}, 32'd7);
      end
      clear_inputs();

      // Shift masking
      id_valid = 1; id_aluctrl = 6; id_rs2_addr = 2; id_rs2_data = 32'h55; id_use_rs2 = 1;
      step();
      exm_regwrite = 1; exm_rd = 2; exm_data = 32'h123;
      #1 check("sll_src2", ex_src2, 32'd3);
      id_aluctrl = 8; id_alusrc = 1; id_imm = 32'hFFFF_FFE1;
      step();
      check("sra_src2", ex_src2, 32'd1);
      clear_inputs();

      // Store data from MEM/WB with immediate offset
      id_valid = 1; id_aluctrl = 2; id_alusrc = 1; id_imm = 8; id_rs2_addr = 6;
      id_rs2_data = 1; id_use_rs2 = 1; id_memwrite = 1;
      step();
      mwb_regwrite = 1; mwb_rd = 6; mwb_data = 32'hDEAD;
      #1 check("sw_src2", ex_src2, 32'd8);
      check("sw_store", ex_store_data, 32'hDEAD);
      clear_inputs();

      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 99) < 2);
         freeze       = ($urandom_range(0, 99) < 15);
         flush        = ($urandom_range(0, 99) < 10);
         id_valid     = ($urandom_range(0, 99) < 80);
         id_rs1_addr  = 5'($urandom_range(0, 3));
         id_rs2_addr  = 5'($urandom_range(0, 3));
         id_rd_addr   = 5'($urandom_range(0, 3));
         id_rs1_data  = $urandom;
         id_rs2_data  = $urandom;
         id_imm       = $urandom;
         id_use_rs2   = ($urandom_range(0, 99) < 70);
         id_alusrc    = $urandom_range(0, 1) == 1;
         id_aluctrl   = 4'($urandom_range(0, 15));
         id_regwrite  = $urandom_range(0, 1) == 1;
         id_memread   = ($urandom_range(0, 99) < 35);
         id_memwrite  = $urandom_range(0, 1) == 1;
         id_memtoreg  = $urandom_range(0, 1) == 1;
         exm_regwrite = ($urandom_range(0, 99) < 60);
         exm_rd       = 5'($urandom_range(0, 3));
         exm_data     = $urandom;
         mwb_regwrite = ($urandom_range(0, 99) < 60);
         mwb_rd       = 5'($urandom_range(0, 3));
         mwb_data     = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
